// File: rtl/filter_menu_pkg.sv
// Shared types and constants for the filter menu front end.
package filter_menu_pkg;

    typedef enum logic [1:0] {
        StIdle        = 2'd0,
        StIssue       = 2'd1,
        StConfirm     = 2'd2,
        StWaitRelease = 2'd3
    } menu_state_e;

    localparam logic [1:0] FILTER_SEPIA  = 2'b00;
    localparam logic [1:0] FILTER_INVERT = 2'b01;

    localparam int unsigned NUM_ENTRIES = 4;
    localparam int unsigned CURSOR_W    = $clog2(NUM_ENTRIES);

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchronizer, stability counter and one-cycle press pulse for one raw button.
module button_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 650000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic level,
    output logic press
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             level_q;
    logic             level_prev_q;
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            level_q      <= 1'b0;
            level_prev_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            sync1_q      <= btn;
            sync2_q      <= sync1_q;
            level_prev_q <= level_q;
            if (sync2_q == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                level_q <= sync2_q;
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign level = level_q;
    // Edge taken against the registered previous level, so it lasts exactly one cycle.
    assign press = level_q & ~level_prev_q;

endmodule

// File: rtl/filter_menu_ctrl.sv
// Button-driven menu cursor that issues filter select pulses and confirms them against
// the filter stage's reported active filter, with a timeout.
module filter_menu_ctrl
    import filter_menu_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 650000,
    parameter int unsigned CONFIRM_TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                menu_en,
    input  logic                btn_up,
    input  logic                btn_down,
    input  logic                btn_enter,
    input  logic [1:0]          filter_status,
    output logic                filters_user_in_en,
    output logic                select0,
    output logic                select1,
    output logic                select2,
    output logic                select3,
    output logic [CURSOR_W-1:0] cursor,
    output logic                busy,
    output logic                sel_ok,
    output logic                sel_err
);

    localparam int unsigned TIMER_W = (CONFIRM_TIMEOUT > 1) ? $clog2(CONFIRM_TIMEOUT) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(CONFIRM_TIMEOUT - 1);

    logic up_level, down_level, enter_level;
    logic up_press, down_press, enter_press;
    logic unused_levels;

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_up),
        .level (up_level),
        .press (up_press)
    );

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_down (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_down),
        .level (down_level),
        .press (down_press)
    );

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_enter (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_enter),
        .level (enter_level),
        .press (enter_press)
    );

    assign unused_levels = up_level ^ down_level;

    menu_state_e          state_q;
    logic [TIMER_W-1:0]   timer_q;
    logic [NUM_ENTRIES-1:0] select_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q            <= StIdle;
            timer_q            <= '0;
            select_q           <= '0;
            cursor             <= '0;
            busy               <= 1'b0;
            sel_ok             <= 1'b0;
            sel_err            <= 1'b0;
            filters_user_in_en <= 1'b0;
        end else begin
            filters_user_in_en <= menu_en;
            select_q           <= '0;
            if (state_q != StIdle && !menu_en) begin
                // Abort: drop back without touching the sticky result flags.
                state_q <= StIdle;
                busy    <= 1'b0;
                timer_q <= '0;
            end else begin
                case (state_q)
                    StIdle: begin
                        if (menu_en) begin
                            if (up_press && !down_press) begin
                                cursor <= cursor - 1'b1;
                            end else if (down_press && !up_press) begin
                                cursor <= cursor + 1'b1;
                            end else if (enter_press && !up_press && !down_press) begin
                                state_q          <= StIssue;
                                busy             <= 1'b1;
                                select_q[cursor] <= 1'b1;
                                sel_ok           <= 1'b0;
                                sel_err          <= 1'b0;
                                timer_q          <= '0;
                            end
                        end
                    end
                    StIssue: state_q <= StConfirm;
                    StConfirm: begin
                        if (filter_status == cursor) begin
                            sel_ok  <= 1'b1;
                            state_q <= StWaitRelease;
                        end else if (timer_q == TIMER_LAST) begin
                            sel_err <= 1'b1;
                            state_q <= StWaitRelease;
                        end else begin
                            timer_q <= timer_q + 1'b1;
                        end
                    end
                    StWaitRelease: begin
                        if (!enter_level) begin
                            state_q <= StIdle;
                            busy    <= 1'b0;
                        end
                    end
                    default: begin
                        state_q <= StIdle;
                        busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign select0 = select_q[0];
    assign select1 = select_q[1];
    assign select2 = select_q[2];
    assign select3 = select_q[3];

endmodule

// File: tb/tb_filter_menu_ctrl.sv
// Directed bench for filter_menu_ctrl with a small filter-stage model.
module tb_filter_menu_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       menu_en = 1'b0;
    logic       btn_up = 1'b0;
    logic       btn_down = 1'b0;
    logic       btn_enter = 1'b0;
    logic [1:0] filter_status;
    logic       filters_user_in_en;
    logic       select0, select1, select2, select3;
    logic [1:0] cursor;
    logic       busy, sel_ok, sel_err;

    int checks = 0;
    int errors = 0;

    // Results recorded by run_enter.
    int first_sel[4];
    int sel_cnt;
    int first_ok;
    int first_err;
    int first_stat1;

    filter_menu_ctrl #(
        .DEBOUNCE_CYCLES (4),
        .CONFIRM_TIMEOUT (8)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .menu_en            (menu_en),
        .btn_up             (btn_up),
        .btn_down           (btn_down),
        .btn_enter          (btn_enter),
        .filter_status      (filter_status),
        .filters_user_in_en (filters_user_in_en),
        .select0            (select0),
        .select1            (select1),
        .select2            (select2),
        .select3            (select3),
        .cursor             (cursor),
        .busy               (busy),
        .sel_ok             (sel_ok),
        .sel_err            (sel_err)
    );

    always #5 clk = ~clk;

    // Filter stage model: latches select0/select1 one cycle later.
    always @(posedge clk) begin
        if (!rst) filter_status <= 2'd0;
        else if (select0) filter_status <= 2'd0;
        else if (select1) filter_status <= 2'd1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic press_btn(input bit up, input bit down);
        btn_up = up;
        btn_down = down;
        repeat (8) tick();
        btn_up = 1'b0;
        btn_down = 1'b0;
        repeat (8) tick();
    endtask

    // Holds enter for n cycles, recording when selects and flags first appear.
    task automatic run_enter(input int n);
        for (int k = 0; k < 4; k++) first_sel[k] = -1;
        sel_cnt = 0;
        first_ok = -1;
        first_err = -1;
        first_stat1 = -1;
        btn_enter = 1'b1;
        for (int t = 1; t <= n; t++) begin
            tick();
            if (select0 && first_sel[0] < 0) first_sel[0] = t;
            if (select1 && first_sel[1] < 0) first_sel[1] = t;
            if (select2 && first_sel[2] < 0) first_sel[2] = t;
            if (select3 && first_sel[3] < 0) first_sel[3] = t;
            sel_cnt += int'(select0) + int'(select1) + int'(select2) + int'(select3);
            if (sel_ok && first_ok < 0) first_ok = t;
            if (sel_err && first_err < 0) first_err = t;
            if (filter_status == 2'd1 && first_stat1 < 0) first_stat1 = t;
        end
    endtask

    task automatic release_enter(output int cyc);
        btn_enter = 1'b0;
        cyc = -1;
        for (int t = 1; t <= 20; t++) begin
            tick();
            if (!busy) begin
                cyc = t;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        menu_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            btn_up = 1'($urandom_range(0, 1));
            btn_down = 1'($urandom_range(0, 1));
            btn_enter = 1'($urandom_range(0, 1));
            tick();
        end
        checks++;
        if ({select3, select2, select1, select0} !== 4'b0) begin
            errors++; $display("FAIL reset_selects: got %b want 0000", {select3, select2, select1, select0});
        end
        checks++;
        if ({busy, sel_ok, sel_err, filters_user_in_en} !== 4'b0) begin
            errors++; $display("FAIL reset_flags: got %b want 0000", {busy, sel_ok, sel_err, filters_user_in_en});
        end
        checks++;
        if (cursor !== 2'd0) begin
            errors++; $display("FAIL reset_cursor: got %0d want 0", cursor);
        end
        btn_up = 1'b0;
        btn_down = 1'b0;
        btn_enter = 1'b0;
        rst = 1'b1;
        tick();
        checks++;
        if (filters_user_in_en !== 1'b1) begin
            errors++; $display("FAIL user_in_en: got %b want 1", filters_user_in_en);
        end
        repeat (10) tick();
        checks++;
        if (cursor !== 2'd0 || busy !== 1'b0) begin
            errors++; $display("FAIL post_reset_idle: got cursor %0d busy %b want 0 0", cursor, busy);
        end
    endtask

    task automatic test_glitch();
        int changes;
        logic [1:0] prev;
        btn_down = 1'b1;
        repeat (3) tick();
        btn_down = 1'b0;
        repeat (12) tick();
        checks++;
        if (cursor !== 2'd0) begin
            errors++; $display("FAIL glitch_short: got %0d want 0", cursor);
        end
        changes = 0;
        prev = cursor;
        btn_down = 1'b1;
        for (int i = 1; i <= 22; i++) begin
            if (i == 13) btn_down = 1'b0;
            tick();
            if (cursor !== prev) changes++;
            prev = cursor;
            if (i == 6) begin
                checks++;
                if (cursor !== 2'd0) begin
                    errors++; $display("FAIL glitch_early: got %0d want 0", cursor);
                end
            end
            if (i == 7) begin
                checks++;
                if (cursor !== 2'd1) begin
                    errors++; $display("FAIL glitch_latency: got %0d want 1", cursor);
                end
            end
        end
        checks++;
        if (changes != 1 || cursor !== 2'd1) begin
            errors++; $display("FAIL glitch_once: got changes %0d cursor %0d want 1 1", changes, cursor);
        end
    endtask

    task automatic test_wrap();
        press_btn(1'b1, 1'b0);
        checks++;
        if (cursor !== 2'd0) begin
            errors++; $display("FAIL up_1_to_0: got %0d want 0", cursor);
        end
        press_btn(1'b1, 1'b0);
        checks++;
        if (cursor !== 2'd3) begin
            errors++; $display("FAIL up_wrap: got %0d want 3", cursor);
        end
        press_btn(1'b0, 1'b1);
        checks++;
        if (cursor !== 2'd0) begin
            errors++; $display("FAIL down_wrap: got %0d want 0", cursor);
        end
        press_btn(1'b1, 1'b1);
        checks++;
        if (cursor !== 2'd0) begin
            errors++; $display("FAIL up_down_both: got %0d want 0", cursor);
        end
    endtask

    task automatic test_timeout();
        int cyc;
        press_btn(1'b0, 1'b1);
        press_btn(1'b0, 1'b1);
        checks++;
        if (cursor !== 2'd2) begin
            errors++; $display("FAIL cursor_to_2: got %0d want 2", cursor);
        end
        run_enter(24);
        checks++;
        if (first_sel[2] != 7 || sel_cnt != 1) begin
            errors++; $display("FAIL timeout_select2: got t=%0d count %0d want t=7 count 1", first_sel[2], sel_cnt);
        end
        checks++;
        if (first_err != 16 || first_ok != -1) begin
            errors++; $display("FAIL timeout_err: got err t=%0d ok t=%0d want 16 -1", first_err, first_ok);
        end
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL timeout_busy_held: got %b want 1", busy);
        end
        release_enter(cyc);
        checks++;
        if (cyc < 0 || sel_err !== 1'b1) begin
            errors++; $display("FAIL timeout_release: got cycles %0d sel_err %b want >0 1", cyc, sel_err);
        end
    endtask

    task automatic test_good_select();
        int cyc;
        press_btn(1'b1, 1'b0);
        checks++;
        if (cursor !== 2'd1) begin
            errors++; $display("FAIL cursor_to_1: got %0d want 1", cursor);
        end
        run_enter(30);
        checks++;
        if (first_sel[1] != 7 || sel_cnt != 1) begin
            errors++; $display("FAIL good_select1: got t=%0d count %0d want t=7 count 1", first_sel[1], sel_cnt);
        end
        checks++;
        if (first_sel[0] != -1 || first_sel[2] != -1 || first_sel[3] != -1) begin
            errors++; $display("FAIL good_other_selects: got %0d %0d %0d want -1", first_sel[0], first_sel[2], first_sel[3]);
        end
        checks++;
        if (first_stat1 != 8 || first_ok != 9) begin
            errors++; $display("FAIL good_ok_latency: got status t=%0d ok t=%0d want 8 9", first_stat1, first_ok);
        end
        checks++;
        if (sel_err !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL good_flags: got err %b busy %b want 0 1", sel_err, busy);
        end
        release_enter(cyc);
        checks++;
        if (cyc < 0 || sel_ok !== 1'b1) begin
            errors++; $display("FAIL good_release: got cycles %0d sel_ok %b want >0 1", cyc, sel_ok);
        end
    endtask

    task automatic test_abort();
        int pulses;
        press_btn(1'b0, 1'b1);
        btn_enter = 1'b1;
        repeat (10) tick();
        checks++;
        if (busy !== 1'b1 || sel_ok !== 1'b0) begin
            errors++; $display("FAIL abort_in_confirm: got busy %b ok %b want 1 0", busy, sel_ok);
        end
        menu_en = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0 || sel_ok !== 1'b0 || sel_err !== 1'b0 || filters_user_in_en !== 1'b0) begin
            errors++; $display("FAIL abort_idle: got busy %b ok %b err %b en %b want 0 0 0 0", busy, sel_ok, sel_err, filters_user_in_en);
        end
        pulses = 0;
        btn_enter = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            pulses += int'(select0) + int'(select1) + int'(select2) + int'(select3) + int'(busy);
        end
        menu_en = 1'b1;
        repeat (3) tick();
        checks++;
        if (pulses != 0 || busy !== 1'b0 || cursor !== 2'd2) begin
            errors++; $display("FAIL abort_quiet: got pulses %0d busy %b cursor %0d want 0 0 2", pulses, busy, cursor);
        end
        btn_enter = 1'b1;
        repeat (10) tick();
        rst = 1'b0;
        tick();
        checks++;
        if ({select3, select2, select1, select0, busy, sel_ok, sel_err, filters_user_in_en} !== 8'b0 || cursor !== 2'd0) begin
            errors++; $display("FAIL abort_reset: got outs %b cursor %0d want 0 0",
                {select3, select2, select1, select0, busy, sel_ok, sel_err, filters_user_in_en}, cursor);
        end
        btn_enter = 1'b0;
        rst = 1'b1;
        repeat (10) tick();
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_glitch();
        test_wrap();
        test_timeout();
        test_good_select();
        test_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
